// File: rtl/out_stream_collector.sv
// ---------------------------------------------------------------------------
// out_stream_collector
//
// Downstream stage of the multi-core matmul toplevel. Result words streamed
// out of the output buffer are queued in a first-word fall-through FIFO and
// re-emitted as an AXI-Stream master. The write side tracks the position of
// each word inside the result matrix (word within a burst, burst within the
// matrix) so that the final word of every matrix is tagged with TLAST.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   in_valid       in_data valid this cycle; the source cannot be stalled
//   in_data        result word (WIDTH*CHUNK_SIZE bits)
//   m_axis_tdata   head-of-FIFO word (0 while the FIFO is empty)
//   m_axis_tvalid  FIFO not empty
//   m_axis_tready  downstream accepts the current beat
//   m_axis_tlast   head word is the last word of a result matrix
//   frame_done     one-cycle pulse in the cycle after a TLAST beat handshake
//   overflow       sticky: an input word was dropped because the FIFO was full
//   busy           write FSM is mid-frame or the FIFO holds data
//   fifo_count     current FIFO occupancy, 0..FIFO_DEPTH
//   dbg_state      write FSM state (0 = IDLE, 1 = ACTIVE)
//
// Handshake: a beat transfers on every rising edge where m_axis_tvalid and
// m_axis_tready are both 1. Once m_axis_tvalid is raised it stays high, and
// m_axis_tdata/m_axis_tlast stay unchanged, until that beat transfers.
// m_axis_tvalid never depends combinationally on m_axis_tready.
//
// FIFO_DEPTH must be a power of two and at least 2 so that the pointers wrap
// naturally at their own width.
// ---------------------------------------------------------------------------
module out_stream_collector #(
    parameter int WIDTH      = 16,
    parameter int CHUNK_SIZE = 4,
    parameter int NUM_CORES  = 4,
    parameter int NUM_BLOCKS = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [WIDTH*CHUNK_SIZE-1:0]   in_data,
    output logic [WIDTH*CHUNK_SIZE-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          frame_done,
    output logic                          overflow,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          dbg_state
);

    localparam int DW   = WIDTH * CHUNK_SIZE;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    // Counter widths are kept at least 1 bit so NUM_CORES/NUM_BLOCKS = 1 still elaborate.
    localparam int WC_W = (NUM_CORES  > 1) ? $clog2(NUM_CORES)  : 1;
    localparam int BC_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(NUM_CORES - 1);
    localparam logic [BC_W-1:0] BLK_LAST  = BC_W'(NUM_BLOCKS - 1);
    localparam logic [CW-1:0]   COUNT_MAX = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } wr_state_t;

    // -----------------------------------------------------------------------
    // Storage and pointers. Each entry is {tlast_tag, data}.
    // -----------------------------------------------------------------------
    logic [DW:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    logic [WC_W-1:0] word_cnt_q;
    logic [BC_W-1:0] blk_cnt_q;
    wr_state_t       state_q;
    wr_state_t       state_d;

    logic            frame_done_q;
    logic            overflow_q;

    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;
    logic            tlast_tag;
    logic [DW:0]     head;

    assign empty = (count_q == '0);
    assign full  = (count_q == COUNT_MAX);

    // Pop only looks at registered occupancy, so a word pushed into an empty
    // FIFO is never presented in the same cycle it arrives.
    assign pop  = !empty && m_axis_tready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    assign tlast_tag = (word_cnt_q == WORD_LAST) && (blk_cnt_q == BLK_LAST);

    assign head = mem[rd_ptr_q];

    // -----------------------------------------------------------------------
    // Storage array: no reset needed, contents are only visible through the
    // pointers, which are reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr_q] <= {tlast_tag, in_data};
        end
    end

    // -----------------------------------------------------------------------
    // Pointers and occupancy.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Matrix position counters: advance only on accepted words, so a dropped
    // word does not shift the TLAST position of later words.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
            blk_cnt_q  <= '0;
        end else if (push) begin
            if (word_cnt_q == WORD_LAST) begin
                word_cnt_q <= '0;
                if (blk_cnt_q == BLK_LAST) begin
                    blk_cnt_q <= '0;
                end else begin
                    blk_cnt_q <= blk_cnt_q + BC_W'(1);
                end
            end else begin
                word_cnt_q <= word_cnt_q + WC_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Write FSM: ACTIVE while a matrix is partially written. A single-word
    // matrix enters and leaves on the same push, so it never leaves IDLE.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (push && !tlast_tag) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (push && tlast_tag) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Status flags.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= pop && head[DW];
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Data/last are forced to 0 when empty so the reset state and
    // idle bus are clean regardless of stale storage contents.
    // -----------------------------------------------------------------------
    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? '0   : head[DW-1:0];
    assign m_axis_tlast  = empty ? 1'b0 : head[DW];
    assign frame_done    = frame_done_q;
    assign overflow      = overflow_q;
    assign busy          = (state_q == ST_ACTIVE) || !empty;
    assign fifo_count    = count_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_out_stream_collector.sv
// ---------------------------------------------------------------------------
// tb_out_stream_collector
//
// Directed bench for out_stream_collector. Instance "dut_a" uses 4 words per
// burst and 2 bursts per matrix (8-word frames) with a 16-entry FIFO; instance
// "dut_b" uses single-word frames. Outputs are sampled 1 time unit after the
// rising edge; inputs are changed at that same point.
// ---------------------------------------------------------------------------
module tb_out_stream_collector;

    localparam int DW = 64;

    logic          clk;
    logic          rst_n;

    logic          a_in_valid;
    logic [DW-1:0] a_in_data;
    logic [DW-1:0] a_tdata;
    logic          a_tvalid;
    logic          a_tready;
    logic          a_tlast;
    logic          a_fd;
    logic          a_ovf;
    logic          a_busy;
    logic [4:0]    a_cnt;
    logic          a_dbg;

    logic          b_in_valid;
    logic [DW-1:0] b_in_data;
    logic [DW-1:0] b_tdata;
    logic          b_tvalid;
    logic          b_tready;
    logic          b_tlast;
    logic          b_fd;
    logic          b_ovf;
    logic          b_busy;
    logic [4:0]    b_cnt;
    logic          b_dbg;

    int checks   = 0;
    int failures = 0;

    logic [DW:0] exp_q[$];

    out_stream_collector #(
        .WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(4), .NUM_BLOCKS(2), .FIFO_DEPTH(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data),
        .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
        .m_axis_tlast(a_tlast), .frame_done(a_fd), .overflow(a_ovf), .busy(a_busy),
        .fifo_count(a_cnt), .dbg_state(a_dbg)
    );

    out_stream_collector #(
        .WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(1), .NUM_BLOCKS(1), .FIFO_DEPTH(16)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
        .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
        .m_axis_tlast(b_tlast), .frame_done(b_fd), .overflow(b_ovf), .busy(b_busy),
        .fifo_count(b_cnt), .dbg_state(b_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stream one 8-word frame through dut_a with tready held high.
    task automatic stream_frame(input logic [DW-1:0] base, input string tag);
        a_tready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            a_in_valid = (k < 8);
            a_in_data  = base + DW'(k);
            step();
            a_in_valid = 1'b0;
            if (k < 8) begin
                chk({tag, "_tvalid"}, a_tvalid, 1'b1);
                chk({tag, "_tdata"},  a_tdata,  base + DW'(k));
                chk({tag, "_tlast"},  a_tlast,  (k == 7));
                chk({tag, "_count"},  a_cnt,    5'd1);
                chk({tag, "_fd_lo"},  a_fd,     1'b0);
                chk({tag, "_state"},  a_dbg,    (k != 7));
            end else if (k == 8) begin
                chk({tag, "_tvalid_end"}, a_tvalid, 1'b0);
                chk({tag, "_fd_pulse"},   a_fd,     1'b1);
                chk({tag, "_count_end"},  a_cnt,    5'd0);
                chk({tag, "_busy_end"},   a_busy,   1'b0);
            end else begin
                chk({tag, "_fd_once"}, a_fd, 1'b0);
            end
        end
    endtask

    // Drain dut_a, expecting words base+first .. base+last; tlast/frame_done
    // are expected on frame positions 7 and 15 (position == word index).
    task automatic drain(input logic [DW-1:0] base, input int first, input int last,
                         input string tag);
        a_tready = 1'b1;
        for (int j = first; j <= last; j++) begin
            chk({tag, "_tvalid"}, a_tvalid, 1'b1);
            chk({tag, "_tdata"},  a_tdata,  base + DW'(j));
            chk({tag, "_tlast"},  a_tlast,  (j == 7 || j == 15));
            step();
            chk({tag, "_fd"}, a_fd, (j == 7 || j == 15));
        end
        chk({tag, "_empty"}, a_tvalid, 1'b0);
        chk({tag, "_count0"}, a_cnt, 5'd0);
    endtask

    task automatic pulse_reset();
        a_in_valid = 1'b0;
        a_tready   = 1'b0;
        rst_n      = 1'b0;
        step();
        rst_n      = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int          pushed;
        int          cyc;
        int          n_fd;
        int          n_last;
        logic        hs;
        logic        prev_last_hs;
        logic [DW:0] head_exp;

        rst_n      = 1'b0;
        a_in_valid = 1'b0;
        a_in_data  = '0;
        a_tready   = 1'b0;
        b_in_valid = 1'b0;
        b_in_data  = '0;
        b_tready   = 1'b1;

        step();
        step();
        // Reset state
        chk("rst_count",  a_cnt,    5'd0);
        chk("rst_tvalid", a_tvalid, 1'b0);
        chk("rst_tdata",  a_tdata,  '0);
        chk("rst_tlast",  a_tlast,  1'b0);
        chk("rst_fd",     a_fd,     1'b0);
        chk("rst_ovf",    a_ovf,    1'b0);
        chk("rst_busy",   a_busy,   1'b0);
        chk("rst_state",  a_dbg,    1'b0);
        chk("rst_b_tvalid", b_tvalid, 1'b0);
        chk("rst_b_busy",   b_busy,   1'b0);
        rst_n = 1'b1;

        // 1. Reset mid-stream with 3 queued words
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 64'hDEAD_0000_0000_0000 + DW'(i);
            step();
        end
        a_in_valid = 1'b0;
        chk("t1_count3", a_cnt,  5'd3);
        chk("t1_busy",   a_busy, 1'b1);
        chk("t1_state",  a_dbg,  1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t1_count0", a_cnt,    5'd0);
        chk("t1_tvalid", a_tvalid, 1'b0);
        chk("t1_ovf",    a_ovf,    1'b0);
        chk("t1_state0", a_dbg,    1'b0);
        chk("t1_fd",     a_fd,     1'b0);

        // 2. One 8-word frame, tready=1: frame restarts at word 0 after reset
        stream_frame(64'h1111_0000_0000_0000, "t2");

        // 3. Fill with tready=0, then one extra word is dropped
        a_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 64'h3333_0000_0000_0000 + DW'(i);
            step();
            chk("t3_count", a_cnt, (i < 16) ? 5'(i + 1) : 5'd16);
            chk("t3_ovf",   a_ovf, (i == 16));
        end
        a_in_valid = 1'b0;
        chk("t3_state_after_drop", a_dbg,   1'b0);
        chk("t3_head",             a_tdata, 64'h3333_0000_0000_0000);
        drain(64'h3333_0000_0000_0000, 0, 15, "t3_drain");
        chk("t3_ovf_sticky", a_ovf, 1'b1);
        // Counters must not have advanced on the dropped word
        stream_frame(64'h3B3B_0000_0000_0000, "t3_next");

        // 4. Full FIFO with simultaneous push and pop
        pulse_reset();
        chk("t4_ovf_cleared", a_ovf, 1'b0);
        for (int i = 0; i < 16; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 64'h4444_0000_0000_0000 + DW'(i);
            step();
        end
        chk("t4_full", a_cnt, 5'd16);
        a_in_valid = 1'b1;
        a_in_data  = 64'h4444_0000_0000_0000 + DW'(16);
        a_tready   = 1'b1;
        step();
        a_in_valid = 1'b0;
        a_tready   = 1'b0;
        chk("t4_count_kept", a_cnt,   5'd16);
        chk("t4_ovf_zero",   a_ovf,   1'b0);
        chk("t4_head",       a_tdata, 64'h4444_0000_0000_0001);
        chk("t4_fd",         a_fd,    1'b0);
        drain(64'h4444_0000_0000_0000, 1, 16, "t4_drain");

        // 5. Random tready over three back-to-back frames
        pulse_reset();
        pushed       = 0;
        cyc          = 0;
        n_fd         = 0;
        n_last       = 0;
        prev_last_hs = 1'b0;
        while ((pushed < 24 || exp_q.size() != 0) && cyc < 2000) begin
            chk("t5_tvalid", a_tvalid, (exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                head_exp = exp_q[0];
                chk("t5_head", {a_tlast, a_tdata}, head_exp);
            end
            chk("t5_fd", a_fd, prev_last_hs);
            if (a_fd) n_fd++;

            a_tready   = 1'($urandom_range(0, 1));
            a_in_valid = (cyc % 3 == 0) && (pushed < 24);
            a_in_data  = 64'h5555_0000_0000_0000 + DW'(pushed);
            hs = (exp_q.size() != 0) && a_tready;
            prev_last_hs = hs && exp_q[0][DW];
            if (hs) begin
                if (a_tlast) n_last++;
                void'(exp_q.pop_front());
            end
            if (a_in_valid) begin
                exp_q.push_back({(pushed % 8 == 7), a_in_data});
                pushed++;
            end
            step();
            cyc++;
        end
        a_in_valid = 1'b0;
        chk("t5_timeout", (cyc < 2000), 1'b1);
        chk("t5_fd_last", a_fd, prev_last_hs);
        if (a_fd) n_fd++;
        chk("t5_fd_pulses",   n_fd,   3);
        chk("t5_tlast_beats", n_last, 3);
        chk("t5_ovf",         a_ovf,  1'b0);
        chk("t5_count0",      a_cnt,  5'd0);

        // 6. Single-word frames
        b_tready   = 1'b1;
        b_in_valid = 1'b1;
        b_in_data  = 64'h6666_0123_4567_89AB;
        step();
        b_in_valid = 1'b0;
        chk("t6_tvalid", b_tvalid, 1'b1);
        chk("t6_tdata",  b_tdata,  64'h6666_0123_4567_89AB);
        chk("t6_tlast",  b_tlast,  1'b1);
        chk("t6_state",  b_dbg,    1'b0);
        chk("t6_busy",   b_busy,   1'b1);
        chk("t6_fd_lo",  b_fd,     1'b0);
        step();
        chk("t6_fd_pulse", b_fd,     1'b1);
        chk("t6_empty",    b_tvalid, 1'b0);
        chk("t6_idle",     b_busy,   1'b0);
        step();
        chk("t6_fd_once", b_fd,  1'b0);
        chk("t6_ovf",     b_ovf, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
